// File: rtl/sipo_pkg.sv
// sipo_pkg: shared defaults and sizing helper for the serial-in/parallel-out deserialiser.
package sipo_pkg;
  localparam int WIDTH_DEF = 8;
  localparam bit MSB_FIRST_DEF = 1'b1;
  function automatic int cnt_w(input int width);
    return ($clog2(width) > 1) ? $clog2(width) : 1;
  endfunction
endpackage

// File: rtl/sipo_deser.sv
// sipo_deser: parametrised serial-in/parallel-out deserialiser with valid/ready output and sticky overrun.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = MSB_FIRST_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      serial_in,
  input  logic                      shift_en,
  output logic [WIDTH-1:0]          parallel_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [cnt_w(WIDTH)-1:0]   bit_cnt,
  output logic                      overrun
);
  localparam int CW = cnt_w(WIDTH);
  logic [WIDTH-1:0] r_sreg, r_pout, w_shifted;
  logic [CW-1:0]    r_cnt;
  logic             r_valid, r_ovr, w_done, w_accept;
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shifted = {r_sreg[WIDTH-2:0], serial_in};
    end else begin : g_lsb
      assign w_shifted = {serial_in, r_sreg[WIDTH-1:1]};
    end
  endgenerate
  assign w_done   = shift_en && (r_cnt == CW'(WIDTH - 1));
  // A completing word may replace one that is being consumed in the same cycle.
  assign w_accept = w_done && (!r_valid || out_ready);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_pout  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else if (clr) begin
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_pout  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      if (shift_en) begin
        r_sreg <= w_shifted;
        r_cnt  <= w_done ? '0 : r_cnt + CW'(1);
      end
      if (w_accept) begin
        r_pout  <= w_shifted;
        r_valid <= 1'b1;
      end else if (w_done) begin
        r_ovr <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end
  assign parallel_out = r_pout;
  assign out_valid    = r_valid;
  assign bit_cnt      = r_cnt;
  assign overrun      = r_ovr;
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed and randomized checks of MSB-first and LSB-first deserialisers against a bit-list model.
module tb_sipo_deser;
  logic       clk = 1'b0, rst = 1'b0, clr = 1'b0, serial_in = 1'b0, shift_en = 1'b0, out_ready = 1'b0;
  logic [7:0] pout_m, pout_l;
  logic       valid_m, valid_l, ovr_m, ovr_l;
  logic [2:0] cnt_m, cnt_l;
  int         tests = 0, fails = 0;

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .clr(clr), .serial_in(serial_in), .shift_en(shift_en),
    .parallel_out(pout_m), .out_valid(valid_m), .out_ready(out_ready), .bit_cnt(cnt_m), .overrun(ovr_m));
  sipo_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .clr(clr), .serial_in(serial_in), .shift_en(shift_en),
    .parallel_out(pout_l), .out_valid(valid_l), .out_ready(out_ready), .bit_cnt(cnt_l), .overrun(ovr_l));

  always #5 clk = ~clk;

  // Model: collect received bits in arrival order; on the 8th bit place them by index.
  logic       bits [8];
  int         nb;
  logic       mv, mov, done;
  logic [7:0] mpm, mpl, wm, wl;
  always @(posedge clk or negedge rst) begin
    if (!rst || clr) begin
      nb = 0; mv = 1'b0; mov = 1'b0; mpm = '0; mpl = '0;
    end else begin
      done = 1'b0;
      if (shift_en) begin
        bits[nb] = serial_in;
        nb = nb + 1;
        if (nb == 8) begin
          done = 1'b1;
          nb = 0;
          for (int i = 0; i < 8; i++) begin
            wm[7-i] = bits[i];
            wl[i]   = bits[i];
          end
        end
      end
      if (done && (!mv || out_ready)) begin
        mpm = wm; mpl = wl; mv = 1'b1;
      end else if (done) mov = 1'b1;
      else if (mv && out_ready) mv = 1'b0;
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) if (rst) begin
    chk("m_pout", 64'(pout_m), 64'(mpm));
    chk("l_pout", 64'(pout_l), 64'(mpl));
    chk("m_valid", 64'(valid_m), 64'(mv));
    chk("l_valid", 64'(valid_l), 64'(mv));
    chk("m_cnt", 64'(cnt_m), 64'(nb));
    chk("l_cnt", 64'(cnt_l), 64'(nb));
    chk("m_ovr", 64'(ovr_m), 64'(mov));
    chk("l_ovr", 64'(ovr_l), 64'(mov));
  end

  task automatic cyc(input logic s, input logic e, input logic r, input logic c);
    serial_in = s; shift_en = e; out_ready = r; clr = c;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] w, input logic r);
    for (int i = 7; i >= 0; i--) cyc(w[i], 1'b1, r, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pout", 64'(pout_m), 0);
    chk("rst_valid", 64'(valid_m), 0);
    chk("rst_cnt", 64'(cnt_m), 0);
    rst = 1'b1;
    cyc(0, 0, 1, 0);
    send(8'h1E, 1'b1);
    chk("t1_pout_msb", 64'(pout_m), 64'h1E);
    chk("t1_pout_lsb", 64'(pout_l), 64'h78);
    chk("t1_valid", 64'(valid_m), 1);
    chk("t1_cnt", 64'(cnt_m), 0);
    chk("t1_ovr", 64'(ovr_m), 0);
    cyc(0, 0, 1, 0);
    chk("t1_consumed", 64'(valid_m), 0);
    for (int i = 7; i >= 4; i--) cyc(1'((8'h1E >> i) & 8'h1), 1, 1, 0);
    repeat (3) begin
      cyc(1, 0, 1, 0);
      chk("t3_gap_cnt", 64'(cnt_m), 4);
    end
    for (int i = 3; i >= 0; i--) cyc(1'((8'h1E >> i) & 8'h1), 1, 1, 0);
    chk("t3_pout", 64'(pout_m), 64'h1E);
    cyc(0, 0, 1, 0);
    send(8'hA5, 1'b0);
    chk("t4_first", 64'(pout_m), 64'hA5);
    send(8'h3C, 1'b0);
    chk("t4_hold", 64'(pout_m), 64'hA5);
    chk("t4_valid", 64'(valid_m), 1);
    chk("t4_ovr", 64'(ovr_m), 1);
    cyc(0, 0, 1, 0);
    chk("t4_drain", 64'(valid_m), 0);
    chk("t4_sticky", 64'(ovr_m), 1);
    cyc(1, 1, 0, 1);
    chk("t4_clr_ovr", 64'(ovr_m), 0);
    chk("t4_clr_pout", 64'(pout_m), 0);
    chk("t4_clr_cnt", 64'(cnt_m), 0);
    send(8'h11, 1'b0);
    for (int i = 7; i >= 0; i--) cyc(1'((8'h22 >> i) & 8'h1), 1, i == 0, 0);
    chk("t5_pout", 64'(pout_m), 64'h22);
    chk("t5_valid", 64'(valid_m), 1);
    chk("t5_ovr", 64'(ovr_m), 0);
    for (int i = 0; i < 5; i++) cyc(1'(i & 1), 1, 0, 0);
    chk("t6_cnt5", 64'(cnt_m), 5);
    #2 rst = 1'b0;
    #1;
    chk("t6_async_cnt", 64'(cnt_m), 0);
    chk("t6_async_valid", 64'(valid_m), 0);
    chk("t6_async_pout", 64'(pout_m), 0);
    @(negedge clk);
    rst = 1'b1;
    send(8'hC3, 1'b1);
    chk("t6_pout_msb", 64'(pout_m), 64'hC3);
    chk("t6_pout_lsb", 64'(pout_l), 64'hC3);
    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
          $urandom_range(0, 99) < 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
Parametrised serial-in/parallel-out deserialiser. It is the successor to the fixed 4-bit SIPO.
- Assembles WIDTH serial bits into a word, MSB-first or LSB-first.
- Bits are shifted only when qualified by shift_en.
- Each completed word is presented on a registered parallel port with a valid/ready handshake.
- Sits between a serial link front end and word-oriented downstream logic. Flags overrun when downstream stalls.

Parameters:
WIDTH, 8, word width in bits; legal range 2..64.
MSB_FIRST, 1, 1 = first received bit ends in parallel_out[WIDTH-1]; 0 = first received bit ends in parallel_out[0].

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
clr  input  1  synchronous clear; flushes partial word and flags
serial_in  input  1  serial data bit
shift_en  input  1  sample serial_in this cycle
parallel_out  output  WIDTH  last accepted complete word
out_valid  output  1  parallel_out holds an unconsumed word
out_ready  input  1  downstream accepts word when out_valid high
bit_cnt  output  $clog2(WIDTH)  bits received of current partial word
overrun  output  1  sticky: a completed word was dropped

Behaviour:
- Reset (rst low, asynchronous): shift register = 0, bit_cnt = 0, parallel_out = 0, out_valid = 0, overrun = 0. Any partial word is discarded.
- Priority each rising edge: clr > shift/complete > handshake.
- clr = 1: shift register = 0, bit_cnt = 0, out_valid = 0, overrun = 0, parallel_out = 0. serial_in is ignored that cycle.
- shift_en = 1 shifts the internal register:
  - MSB_FIRST = 1: sreg <= {sreg[WIDTH-2:0], serial_in}.
  - MSB_FIRST = 0: sreg <= {serial_in, sreg[WIDTH-1:1]}.
  - bit_cnt increments by 1.
- shift_en = 0: sreg and bit_cnt hold. Gaps of any length are legal.
- Completion occurs when shift_en = 1 and bit_cnt == WIDTH-1:
  - The completed word is the shifted value including the current serial_in.
  - bit_cnt wraps to 0 and sreg continues shifting normally (no clear needed).
- Accept rule on completion:
  - If out_valid == 0, or out_valid == 1 and out_ready == 1 in the same cycle: parallel_out <= word and out_valid <= 1.
  - Otherwise (out_valid == 1, out_ready == 0): the word is dropped, parallel_out holds, and overrun <= 1.
- Handshake: out_valid && out_ready with no completion that cycle clears out_valid on the next edge. parallel_out holds its value after consumption.
- Latency: out_valid rises on the same edge that samples the last bit, so it is visible the cycle after the last bit is presented. WIDTH shift_en cycles produce one word.
- Back-to-back: consecutive words with out_ready held high give one out_valid cycle per word, with no dead cycle required.
- overrun is sticky until clr or rst. Once set, it does not stop further accepts.
- out_ready while out_valid = 0 is ignored.
- bit_cnt never exceeds WIDTH-1.

Decomposition:
- Package sipo_pkg: function cnt_w(width) returning max(1, $clog2(width)), and localparam defaults WIDTH_DEF = 8 and MSB_FIRST_DEF = 1.
- Single module, no sub-module. The direction-select shift is one generate branch inside sipo_deser.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, out_ready=1; shift serial 0,0,0,1,1,1,1,0 on 8 consecutive cycles -> parallel_out = 8'h1E, out_valid high 1 cycle, bit_cnt back to 0, overrun = 0.
2. MSB_FIRST=0, same serial sequence -> parallel_out = 8'h78.
3. MSB_FIRST=1; same bits with shift_en low for 3 cycles between bits 4 and 5 -> bit_cnt holds at 4 during the gap, final word 8'h1E.
4. out_ready=0; send 8'hA5 then 8'h3C -> parallel_out stays 8'hA5, out_valid stays 1, overrun = 1. Then out_ready=1 for 1 cycle -> out_valid = 0, overrun still 1. Then pulse clr -> overrun = 0, parallel_out = 0.
5. Accept collision: out_valid high from word 8'h11; out_ready=1 in the exact cycle word 8'h22 completes -> parallel_out = 8'h22, out_valid stays 1, no overrun.
6. Reset mid-operation: after 5 bits, drive rst low asynchronously between edges -> bit_cnt, out_valid, parallel_out are 0 immediately. After release, a fresh 8 bits of 8'hC3 -> parallel_out = 8'hC3.
